// File: rtl/axil_rr_arbiter.sv
// axil_rr_arbiter: N-master to 1-slave AXI4-Lite arbiter with round-robin fairness.
//
// Exactly one transaction (read or write) is in flight at a time. The winner's address,
// write data and strobes are registered at grant time, so no slave ready combinationally
// reaches a master valid. A grant is held until the response handshake completes.
//
// Ports (m_* buses packed, master i occupies bits [i*W +: W]):
//   clk, rst            single clock, synchronous active-high reset
//   m_ar*/m_r*          per-master read address / read data channels
//   m_aw*/m_w*/m_b*     per-master write address / write data / write response channels
//   s_*                 single slave port, same 17 signals with directions reversed
module axil_rr_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    // master side
    input  logic [NUM_MASTERS*ADDR_W-1:0]     m_araddr,
    input  logic [NUM_MASTERS-1:0]            m_arvalid,
    output logic [NUM_MASTERS-1:0]            m_arready,
    output logic [NUM_MASTERS*DATA_W-1:0]     m_rdata,
    output logic [NUM_MASTERS*2-1:0]          m_rresp,
    output logic [NUM_MASTERS-1:0]            m_rvalid,
    input  logic [NUM_MASTERS-1:0]            m_rready,
    input  logic [NUM_MASTERS*ADDR_W-1:0]     m_awaddr,
    input  logic [NUM_MASTERS-1:0]            m_awvalid,
    output logic [NUM_MASTERS-1:0]            m_awready,
    input  logic [NUM_MASTERS*DATA_W-1:0]     m_wdata,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_wstrb,
    input  logic [NUM_MASTERS-1:0]            m_wvalid,
    output logic [NUM_MASTERS-1:0]            m_wready,
    output logic [NUM_MASTERS*2-1:0]          m_bresp,
    output logic [NUM_MASTERS-1:0]            m_bvalid,
    input  logic [NUM_MASTERS-1:0]            m_bready,
    // slave side
    output logic [ADDR_W-1:0]                 s_araddr,
    output logic                              s_arvalid,
    input  logic                              s_arready,
    input  logic [DATA_W-1:0]                 s_rdata,
    input  logic [1:0]                        s_rresp,
    input  logic                              s_rvalid,
    output logic                              s_rready,
    output logic [ADDR_W-1:0]                 s_awaddr,
    output logic                              s_awvalid,
    input  logic                              s_awready,
    output logic [DATA_W-1:0]                 s_wdata,
    output logic [DATA_W/8-1:0]               s_wstrb,
    output logic                              s_wvalid,
    input  logic                              s_wready,
    input  logic [1:0]                        s_bresp,
    input  logic                              s_bvalid,
    output logic                              s_bready
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StRdD,
        StWrA,
        StWrB
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] sel;
    logic                   found;
    logic [IDX_W-1:0]       winner;
    logic                   win_wr;
    logic [ADDR_W-1:0]      win_araddr;
    logic [ADDR_W-1:0]      win_awaddr;
    logic [DATA_W-1:0]      win_wdata;
    logic [STRB_W-1:0]      win_wstrb;

    // Round-robin pick: first requester scanning from ptr+1 modulo N. Slave readiness is
    // deliberately not consulted.
    always_comb begin
        req    = m_arvalid | (m_awvalid & m_wvalid);
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= int'(NUM_MASTERS); k++) begin
            for (int i = 0; i < int'(NUM_MASTERS); i++) begin
                if (!found && req[i] && ((int'(ptr_q) + k) % int'(NUM_MASTERS)) == i) begin
                    found  = 1'b1;
                    winner = IDX_W'(i);
                end
            end
        end
    end

    // Fields of the candidate winner; a pending write beats a pending read of the same master.
    always_comb begin
        win_wr     = 1'b0;
        win_araddr = '0;
        win_awaddr = '0;
        win_wdata  = '0;
        win_wstrb  = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (IDX_W'(i) == winner) begin
                win_wr     = m_awvalid[i] & m_wvalid[i];
                win_araddr = m_araddr[i*ADDR_W +: ADDR_W];
                win_awaddr = m_awaddr[i*ADDR_W +: ADDR_W];
                win_wdata  = m_wdata[i*DATA_W +: DATA_W];
                win_wstrb  = m_wstrb[i*STRB_W +: STRB_W];
            end
        end
    end

    // One-hot of the currently granted master, used to steer master-side outputs.
    always_comb begin
        sel = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            sel[i] = (IDX_W'(i) == grant_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= IDX_W'(NUM_MASTERS - 1);
            grant_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    logic aw_hs;
    logic w_hs;
    logic g_rready;
    logic g_bready;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        g_rready  = |(m_rready & sel);
        g_bready  = |(m_bready & sel);

        m_arready = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rvalid  = '0;
        m_awready = '0;
        m_wready  = '0;
        m_bresp   = '0;
        m_bvalid  = '0;
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    ptr_d     = winner;
                    grant_d   = winner;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (win_wr) begin
                        state_d = StWrA;
                        addr_d  = win_awaddr;
                        wdata_d = win_wdata;
                        wstrb_d = win_wstrb;
                    end else begin
                        state_d = StRdA;
                        addr_d  = win_araddr;
                    end
                end
            end
            StRdA: begin
                s_arvalid = 1'b1;
                s_araddr  = addr_q;
                if (s_arready) begin
                    m_arready = sel;
                    state_d   = StRdD;
                end
            end
            StRdD: begin
                s_rready = g_rready;
                m_rvalid = s_rvalid ? sel : '0;
                for (int i = 0; i < int'(NUM_MASTERS); i++) begin
                    if (sel[i]) begin
                        m_rdata[i*DATA_W +: DATA_W] = s_rdata;
                        m_rresp[i*2 +: 2]           = s_rresp;
                    end
                end
                if (s_rvalid && g_rready) begin
                    state_d = StIdle;
                end
            end
            StWrA: begin
                // AW and W complete independently; each valid drops once its handshake is done.
                s_awvalid = !aw_done_q;
                s_wvalid  = !w_done_q;
                s_awaddr  = addr_q;
                s_wdata   = wdata_q;
                s_wstrb   = wstrb_q;
                aw_hs     = !aw_done_q && s_awready;
                w_hs      = !w_done_q && s_wready;
                m_awready = aw_hs ? sel : '0;
                m_wready  = w_hs ? sel : '0;
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = StWrB;
                end
            end
            StWrB: begin
                s_bready = g_bready;
                m_bvalid = s_bvalid ? sel : '0;
                for (int i = 0; i < int'(NUM_MASTERS); i++) begin
                    if (sel[i]) begin
                        m_bresp[i*2 +: 2] = s_bresp;
                    end
                end
                if (s_bvalid && g_bready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// tb_axil_rr_arbiter: directed bench for axil_rr_arbiter (3 masters, 64-bit data).
// A transaction-level model tracks the owner and phase and checks all outputs each cycle;
// the stimulus thread pins grant order and key cycles with literal expectations.
module tb_axil_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic clk;
    logic rst;

    logic [N*AW-1:0] m_araddr;
    logic [N-1:0]    m_arvalid;
    logic [N-1:0]    m_arready;
    logic [N*DW-1:0] m_rdata;
    logic [N*2-1:0]  m_rresp;
    logic [N-1:0]    m_rvalid;
    logic [N-1:0]    m_rready;
    logic [N*AW-1:0] m_awaddr;
    logic [N-1:0]    m_awvalid;
    logic [N-1:0]    m_awready;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;
    logic [N-1:0]    m_wvalid;
    logic [N-1:0]    m_wready;
    logic [N*2-1:0]  m_bresp;
    logic [N-1:0]    m_bvalid;
    logic [N-1:0]    m_bready;

    logic [AW-1:0] s_araddr;
    logic          s_arvalid;
    logic          s_arready;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rvalid;
    logic          s_rready;
    logic [AW-1:0] s_awaddr;
    logic          s_awvalid;
    logic          s_awready;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_wstrb;
    logic          s_wvalid;
    logic          s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid;
    logic          s_bready;

    axil_rr_arbiter #(
        .NUM_MASTERS(N),
        .ADDR_W     (AW),
        .DATA_W     (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_araddr (m_araddr),
        .m_arvalid(m_arvalid),
        .m_arready(m_arready),
        .m_rdata  (m_rdata),
        .m_rresp  (m_rresp),
        .m_rvalid (m_rvalid),
        .m_rready (m_rready),
        .m_awaddr (m_awaddr),
        .m_awvalid(m_awvalid),
        .m_awready(m_awready),
        .m_wdata  (m_wdata),
        .m_wstrb  (m_wstrb),
        .m_wvalid (m_wvalid),
        .m_wready (m_wready),
        .m_bresp  (m_bresp),
        .m_bvalid (m_bvalid),
        .m_bready (m_bready),
        .s_araddr (s_araddr),
        .s_arvalid(s_arvalid),
        .s_arready(s_arready),
        .s_rdata  (s_rdata),
        .s_rresp  (s_rresp),
        .s_rvalid (s_rvalid),
        .s_rready (s_rready),
        .s_awaddr (s_awaddr),
        .s_awvalid(s_awvalid),
        .s_awready(s_awready),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_wvalid (s_wvalid),
        .s_wready (s_wready),
        .s_bresp  (s_bresp),
        .s_bvalid (s_bvalid),
        .s_bready (s_bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          busy    = 1'b0;
    bit          is_wr   = 1'b0;
    bit          in_resp = 1'b0;
    bit          awd     = 1'b0;
    bit          wd      = 1'b0;
    int          owner   = 0;
    int          last    = N - 1;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [SW-1:0] exp_wstrb;
    int          grants[$];

    logic [N-1:0]    e_arready, e_rvalid, e_awready, e_wready, e_bvalid;
    logic [N*DW-1:0] e_rdata;
    logic [N*2-1:0]  e_rresp, e_bresp;
    logic            e_sarvalid, e_srready, e_sawvalid, e_swvalid, e_sbready;

    always @(negedge clk) begin
        e_arready = '0; e_rvalid = '0; e_awready = '0; e_wready = '0; e_bvalid = '0;
        e_rdata = '0; e_rresp = '0; e_bresp = '0;
        e_sarvalid = 0; e_srready = 0; e_sawvalid = 0; e_swvalid = 0; e_sbready = 0;
        if (busy && !in_resp && !is_wr) begin
            e_sarvalid       = 1'b1;
            e_arready[owner] = s_arready;
            chk("s_araddr", s_araddr, exp_addr);
        end else if (busy && !in_resp && is_wr) begin
            e_sawvalid       = !awd;
            e_swvalid        = !wd;
            e_awready[owner] = !awd && s_awready;
            e_wready[owner]  = !wd && s_wready;
            if (!awd) chk("s_awaddr", s_awaddr, exp_addr);
            if (!wd) begin
                chk("s_wdata", s_wdata, exp_wdata);
                chk("s_wstrb", s_wstrb, exp_wstrb);
            end
        end else if (busy && in_resp && !is_wr) begin
            e_srready                = m_rready[owner];
            e_rvalid[owner]          = s_rvalid;
            e_rdata[owner*DW +: DW]  = s_rdata;
            e_rresp[owner*2 +: 2]    = s_rresp;
        end else if (busy && in_resp && is_wr) begin
            e_sbready             = m_bready[owner];
            e_bvalid[owner]       = s_bvalid;
            e_bresp[owner*2 +: 2] = s_bresp;
        end
        chk("m_arready", m_arready, e_arready);
        chk("m_rvalid",  m_rvalid,  e_rvalid);
        chk("m_rdata",   m_rdata,   e_rdata);
        chk("m_rresp",   m_rresp,   e_rresp);
        chk("m_awready", m_awready, e_awready);
        chk("m_wready",  m_wready,  e_wready);
        chk("m_bvalid",  m_bvalid,  e_bvalid);
        chk("m_bresp",   m_bresp,   e_bresp);
        chk("s_arvalid", s_arvalid, e_sarvalid);
        chk("s_rready",  s_rready,  e_srready);
        chk("s_awvalid", s_awvalid, e_sawvalid);
        chk("s_wvalid",  s_wvalid,  e_swvalid);
        chk("s_bready",  s_bready,  e_sbready);

        // Advance the model to what the coming clock edge does.
        if (rst) begin
            busy = 1'b0;
            last = N - 1;
        end else if (!busy) begin
            for (int k = 1; k <= N && !busy; k++) begin
                int j;
                j = (last + k) % N;
                if (m_arvalid[j] || (m_awvalid[j] && m_wvalid[j])) begin
                    busy    = 1'b1;
                    owner   = j;
                    last    = j;
                    in_resp = 1'b0;
                    awd     = 1'b0;
                    wd      = 1'b0;
                    is_wr   = m_awvalid[j] && m_wvalid[j];
                    exp_addr  = is_wr ? m_awaddr[j*AW +: AW] : m_araddr[j*AW +: AW];
                    exp_wdata = m_wdata[j*DW +: DW];
                    exp_wstrb = m_wstrb[j*SW +: SW];
                    grants.push_back(j);
                end
            end
        end else if (!in_resp) begin
            if (!is_wr) begin
                if (s_arready) in_resp = 1'b1;
            end else begin
                if (s_awready) awd = 1'b1;
                if (s_wready) wd = 1'b1;
                if (awd && wd) in_resp = 1'b1;
            end
        end else begin
            if (!is_wr && s_rvalid && m_rready[owner]) busy = 1'b0;
            if (is_wr && s_bvalid && m_bready[owner]) busy = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int k);
        int cyc = 0;
        while (grants.size() < k && cyc < 200) begin
            step();
            cyc++;
        end
        chk("grant_timeout", 256'(grants.size() >= k), 256'(1));
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (busy && cyc < 200) begin
            step();
            cyc++;
        end
        chk("idle_timeout", 256'(busy), 256'(0));
    endtask

    initial begin
        int cnt[N];
        int order[7];
        order = '{0, 1, 2, 0, 1, 2, 0};

        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            m_araddr[i*AW +: AW] = 32'h1000 * (i + 1);
            m_awaddr[i*AW +: AW] = 32'h8000 * (i + 1);
            m_wdata[i*DW +: DW]  = 64'hA5A5_0000_0000_0000 + 64'(i);
            m_wstrb[i*SW +: SW]  = 8'hFF;
        end
        m_arvalid = 3'b111; m_awvalid = '0; m_wvalid = '0;
        m_rready  = 3'b111; m_bready  = 3'b111;
        s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 64'hDEAD_BEEF_0000_0001; s_rresp = 2'b00;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; s_bresp = 2'b00;

        // 1. Reset with all masters requesting.
        step();
        @(negedge clk);
        chk("rst_s_arvalid", s_arvalid, 1'b0);
        chk("rst_m_arready", m_arready, 3'b000);
        step();
        rst = 1'b0;
        wait_grants(1);
        chk("first_grant", grants[0], 0);
        @(negedge clk);
        chk("first_s_arvalid", s_arvalid, 1'b1);
        chk("first_s_araddr", s_araddr, 32'h1000);

        // 2. Continuous reads from all three: strict rotation.
        wait_grants(7);
        cnt = '{0, 0, 0};
        for (int i = 0; i < 7; i++) begin
            chk("rr_order", grants[i], order[i]);
            if (i < 6) cnt[grants[i]]++;
        end
        for (int i = 0; i < N; i++) chk("rr_share", cnt[i], 2);
        m_arvalid = '0;
        wait_idle();

        // 3. Master 1 with write and read pending: write first, latched fields kept.
        grants.delete();
        s_bvalid = 1'b0; s_bresp = 2'b11;
        m_awaddr[1*AW +: AW] = 32'h2222_0000;
        m_wstrb[1*SW +: SW]  = 8'h0F;
        m_awvalid[1] = 1'b1; m_wvalid[1] = 1'b1; m_arvalid[1] = 1'b1;
        wait_grants(1);
        @(negedge clk);
        chk("wr_first_awvalid", s_awvalid, 1'b1);
        chk("wr_first_arvalid", s_arvalid, 1'b0);
        chk("wr_first_awaddr", s_awaddr, 32'h2222_0000);
        chk("wr_first_wstrb", s_wstrb, 8'h0F);
        step();
        m_awvalid[1] = 1'b0; m_wvalid[1] = 1'b0;
        step();
        step();
        s_bvalid = 1'b1;
        wait_grants(2);
        chk("rd_after_wr", grants[1], 1);
        step();
        m_arvalid = '0;
        wait_idle();
        s_bresp = 2'b00;

        // 4. AW accepted at once, W lags three cycles.
        grants.delete();
        s_awready = 1'b1; s_wready = 1'b0; s_bvalid = 1'b0;
        m_awaddr[2*AW +: AW] = 32'h3333_0000;
        m_wstrb[2*SW +: SW]  = 8'hF0;
        m_awvalid[2] = 1'b1; m_wvalid[2] = 1'b1;
        wait_grants(1);
        @(negedge clk);
        chk("lag_c1_awvalid", s_awvalid, 1'b1);
        chk("lag_c1_wvalid", s_wvalid, 1'b1);
        step();
        m_awvalid[2] = 1'b0;
        @(negedge clk);
        chk("lag_c2_awvalid", s_awvalid, 1'b0);
        chk("lag_c2_wvalid", s_wvalid, 1'b1);
        step();
        step();
        s_wready = 1'b1;
        @(negedge clk);
        chk("lag_c4_wready", m_wready, 3'b100);
        chk("lag_c4_bready", s_bready, 1'b0);
        step();
        m_wvalid[2] = 1'b0;
        @(negedge clk);
        chk("lag_c5_wvalid", s_wvalid, 1'b0);
        chk("lag_c5_bready", s_bready, 1'b1);
        step();
        s_bvalid = 1'b1;
        wait_idle();

        // 5. SLVERR read response held while master 0 stalls.
        grants.delete();
        s_rresp = 2'b10; s_rvalid = 1'b1; m_rready[0] = 1'b0;
        m_arvalid[0] = 1'b1;
        wait_grants(1);
        @(negedge clk);
        chk("slverr_arready", m_arready, 3'b001);
        step();
        m_arvalid[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("slverr_hold_rvalid", m_rvalid, 3'b001);
            chk("slverr_hold_rresp", m_rresp[1:0], 2'b10);
            step();
        end
        m_rready[0] = 1'b1;
        @(negedge clk);
        chk("slverr_hs_rvalid", m_rvalid, 3'b001);
        step();
        @(negedge clk);
        chk("slverr_done_rvalid", m_rvalid, 3'b000);
        s_rresp = 2'b00;
        wait_idle();

        // 6. Reset while waiting in the read-data phase.
        grants.delete();
        s_rvalid = 1'b0;
        m_arvalid[1] = 1'b1;
        wait_grants(1);
        chk("pre_rst_grant", grants[0], 1);
        step();
        m_arvalid[1] = 1'b0;
        @(negedge clk);
        chk("rdd_s_rready", s_rready, 1'b1);
        step();
        rst = 1'b1;
        m_arvalid = 3'b101;
        step();
        rst = 1'b0;
        s_rvalid = 1'b1;
        @(negedge clk);
        chk("post_rst_s_rready", s_rready, 1'b0);
        chk("post_rst_s_arvalid", s_arvalid, 1'b0);
        chk("post_rst_m_rvalid", m_rvalid, 3'b000);
        wait_grants(2);
        chk("post_rst_grant", grants[1], 0);
        step();
        m_arvalid = '0;
        wait_idle();

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
